// File: rtl/iir_cas_pkg.sv
// Shared constants, FSM encoding and coefficient-address decode for the
// time-multiplexed biquad cascade.
package iir_cas_pkg;

  localparam int COEF_FRAC_DEFAULT = 11;
  localparam int NTAPS             = 5;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_e;

  // cfg_addr = stage*5 + tap
  function automatic logic [5:0] cfg_stage(input logic [5:0] addr);
    return addr / 6'd5;
  endfunction

  function automatic logic [2:0] cfg_tap(input logic [5:0] addr);
    return 3'(addr % 6'd5);
  endfunction

endpackage

// File: rtl/iir_cas_sched_mac.sv
// Single signed CW x DW multiplier feeding an AW-bit accumulator; clr restarts
// the sum with the current product, subtract negates the product.
module iir_mac
  #(
    parameter int CW = 13,
    parameter int DW = 12,
    parameter int AW = 28
  ) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 subtract,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] data,
    output logic signed [AW-1:0] acc
  );

  logic signed [CW+DW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    base;
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    acc_d;

  assign prod     = coef * data;
  assign prod_ext = {{(AW-CW-DW){prod[CW+DW-1]}}, prod};
  assign base     = clr ? '0 : acc_q;
  assign acc_d    = subtract ? (base - prod_ext) : (base + prod_ext);
  assign acc      = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_cas_sched.sv
// Scheduler for NSEC cascaded biquads sharing one MAC: 5 MAC cycles plus one
// writeback cycle per stage, then a one-cycle DONE strobe.
module iir_cas_sched
  import iir_cas_pkg::*;
  #(
    parameter int NSEC      = 2,
    parameter int DW        = 12,
    parameter int CW        = 13,
    parameter int COEF_FRAC = COEF_FRAC_DEFAULT,
    parameter int AW        = 28
  ) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          cfg_we,
    input  logic [5:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          clr_state,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          sat_flag,
    output logic          overrun,
    output logic          cfg_err
  );

  // Handshake: in_valid/out_valid are one-cycle strobes with no ready; an
  // in_valid is taken only in IDLE, anywhere else it is dropped and recorded.
  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam logic signed [AW-1:0] Y_MAX  = (AW'(1) <<< (DW-1)) - AW'(1);
  localparam logic signed [AW-1:0] Y_MIN  = -(AW'(1) <<< (DW-1));
  localparam logic signed [CW-1:0] B0_ONE = CW'(1 << COEF_FRAC);

  state_e              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [2:0]          tap_q, tap_d;
  logic                accept, wb, mac_en, mac_clr, last_stage;

  logic signed [CW-1:0] coef_q [NSEC][NTAPS];
  logic signed [DW-1:0] x1_q [NSEC];
  logic signed [DW-1:0] x2_q [NSEC];
  logic signed [DW-1:0] y1_q [NSEC];
  logic signed [DW-1:0] y2_q [NSEC];
  logic signed [DW-1:0] x_cur_q, out_data_q;
  logic                 sat_q, overrun_q, cfg_err_q;

  logic                 cfg_ok;
  logic [SW-1:0]        wr_stage;
  logic [2:0]           wr_tap;
  logic signed [DW-1:0] mac_data;
  logic signed [CW-1:0] mac_coef;
  logic signed [AW-1:0] mac_acc, y_full;
  logic signed [DW-1:0] y_sat;
  logic                 y_clip;

  assign last_stage = (stage_q == SW'(NSEC - 1));

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    tap_d   = tap_q;
    accept  = 1'b0;
    wb      = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_MAC;
          stage_d = '0;
          tap_d   = TAP_B0;
        end
      end
      ST_MAC: begin
        mac_en  = 1'b1;
        mac_clr = (tap_q == TAP_B0);
        if (tap_q == TAP_A2) state_d = ST_WB;
        else                 tap_d   = tap_q + 3'd1;
      end
      ST_WB: begin
        wb = 1'b1;
        if (last_stage) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + SW'(1);
          tap_d   = TAP_B0;
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      tap_q   <= TAP_B0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tap_q   <= tap_d;
    end
  end

  // Operand select on {stage, tap}; a2 is the only subtracted product.
  always_comb begin
    mac_data = x_cur_q;
    case (tap_q)
      TAP_B1:  mac_data = x1_q[stage_q];
      TAP_B2:  mac_data = x2_q[stage_q];
      TAP_A1:  mac_data = y1_q[stage_q];
      TAP_A2:  mac_data = y2_q[stage_q];
      default: mac_data = x_cur_q;
    endcase
  end

  assign mac_coef = coef_q[stage_q][tap_q];

  iir_mac #(.CW(CW), .DW(DW), .AW(AW)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .subtract (tap_q == TAP_A2),
    .coef     (mac_coef),
    .data     (mac_data),
    .acc      (mac_acc)
  );

  always_comb begin
    y_full = mac_acc >>> COEF_FRAC;
    y_clip = 1'b0;
    y_sat  = y_full[DW-1:0];
    if (y_full > Y_MAX) begin
      y_sat  = Y_MAX[DW-1:0];
      y_clip = 1'b1;
    end else if (y_full < Y_MIN) begin
      y_sat  = Y_MIN[DW-1:0];
      y_clip = 1'b1;
    end
  end

  assign wr_stage = SW'(cfg_stage(cfg_addr));
  assign wr_tap   = cfg_tap(cfg_addr);
  // A write colliding with an accepted sample loses to the sample.
  assign cfg_ok   = cfg_we && (state_q == ST_IDLE) && !in_valid &&
                    (cfg_addr < 6'(NTAPS * NSEC));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSEC; s++) begin
        for (int t = 0; t < NTAPS; t++) coef_q[s][t] <= (t == 0) ? B0_ONE : '0;
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
      x_cur_q    <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (in_valid && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      if (accept) x_cur_q <= in_data;
      if (cfg_ok) coef_q[wr_stage][wr_tap] <= cfg_data;
      if ((state_q == ST_IDLE) && clr_state) begin
        for (int s = 0; s < NSEC; s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end
      if (wb) begin
        x2_q[stage_q] <= x1_q[stage_q];
        x1_q[stage_q] <= x_cur_q;
        y2_q[stage_q] <= y1_q[stage_q];
        y1_q[stage_q] <= y_sat;
        x_cur_q       <= y_sat;
        if (y_clip) sat_q <= 1'b1;
        if (last_stage) out_data_q <= y_sat;
      end
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MAC) || (state_q == ST_WB);
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;
  assign overrun   = overrun_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_iir_cas_sched.sv
// Scenario bench for iir_cas_sched (NSEC=2): expected outputs are queued when a
// sample is driven and popped when out_valid appears.
module tb_iir_cas_sched;

  localparam int LAT = 13;

  logic        clk = 1'b0;
  logic        rst, in_valid, cfg_we, clr_state;
  logic [11:0] in_data;
  logic [5:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic        out_valid, busy, sat_flag, overrun, cfg_err;
  logic [11:0] out_data;

  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  iir_cas_sched #(.NSEC(2), .DW(12), .CW(13), .COEF_FRAC(11), .AW(28)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .clr_state (clr_state),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .overrun   (overrun),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Drivers: all start and end on a falling edge.
  task automatic run_sample(input int x, input logic clr, output logic [11:0] got,
                            output int lat, output int busy_cnt);
    in_valid  = 1'b1;
    in_data   = 12'(x);
    clr_state = clr;
    lat = -1; busy_cnt = 0; got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      clr_state = 1'b0;
      if (busy) busy_cnt++;
      if (out_valid) begin
        lat = c;
        got = out_data;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input int val, output logic err);
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_data = 13'(val);
    @(negedge clk);
    cfg_we = 1'b0;
    err    = cfg_err;
  endtask

  task automatic pulse_clr();
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; clr_state = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, busy, sat_flag, overrun, cfg_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b data=%0d busy=%b sat=%b ovr=%b cerr=%b, expected all 0",
               out_valid, out_data, busy, sat_flag, overrun, cfg_err);
    end
  endtask

  task automatic test_passthrough();
    logic [11:0] got, e;
    int lat, bc;
    exp_q.push_back(12'd100);
    run_sample(100, 1'b0, got, lat, bc);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || lat != LAT) begin
      errors++;
      $display("FAIL passthrough: got %0d at cycle %0d, expected %0d at cycle %0d", $signed(got), lat, $signed(e), LAT);
    end
    checks++;
    if (bc != 12) begin
      errors++;
      $display("FAIL busy_window: got %0d busy cycles, expected 12", bc);
    end
  endtask

  task automatic test_fir();
    int xs[4] = '{100, 0, 0, 0};
    int es[4] = '{100, 100, 100, 0};
    logic [11:0] got, e;
    logic err;
    int lat, bc;
    pulse_clr();
    write_coef(1, 2048, err);
    write_coef(2, 2048, err);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_valid_write: got cfg_err=%b, expected 0", err);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(12'(es[i]));
      run_sample(xs[i], 1'b0, got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL fir_%0d: got %0d at cycle %0d, expected %0d at cycle %0d", i, $signed(got), lat, $signed(e), LAT);
      end
    end
    write_coef(1, 0, err);
    write_coef(2, 0, err);
  endtask

  task automatic test_iir();
    int ps[6] = '{1000, 500, 250, 125, 62, 31};
    int ns[5] = '{-1000, -500, -250, -125, -63};
    logic [11:0] got, e;
    logic err;
    int lat, bc;
    write_coef(3, 1024, err);
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(12'(ps[i]));
      run_sample((i == 0) ? 1000 : 0, 1'b0, got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL iir_pos_%0d: got %0d at cycle %0d, expected %0d", i, $signed(got), lat, $signed(e));
      end
    end
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(12'(ns[i]));
      run_sample((i == 0) ? -1000 : 0, 1'b0, got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL iir_neg_%0d: got %0d at cycle %0d, expected %0d", i, $signed(got), lat, $signed(e));
      end
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_quiet: got sat_flag=%b, expected 0", sat_flag);
    end
  endtask

  task automatic test_clr();
    int xs[5] = '{1000, 0, 0, 1000, 0};
    logic cl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int es[5] = '{1000, 500, 0, 1000, 0};
    logic [11:0] got, e;
    int lat, bc;
    // a1=1024 is still loaded from the IIR scenario.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(12'(es[i]));
      run_sample(xs[i], cl[i], got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL clr_%0d: got %0d at cycle %0d, expected %0d", i, $signed(got), lat, $signed(e));
      end
    end
  endtask

  task automatic test_sat();
    logic [11:0] got, e;
    logic err;
    int lat, bc;
    write_coef(3, 0, err);
    write_coef(0, 4095, err);
    exp_q.push_back(12'd2047);
    run_sample(2047, 1'b0, got, lat, bc);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: got %0d sat=%b, expected %0d sat=1", $signed(got), sat_flag, $signed(e));
    end
    exp_q.push_back(12'h800);
    run_sample(-2048, 1'b0, got, lat, bc);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || lat != LAT) begin
      errors++;
      $display("FAIL sat_neg: got %0d at cycle %0d, expected %0d", $signed(got), lat, $signed(e));
    end
    write_coef(0, 2048, err);
  endtask

  task automatic test_overrun();
    logic [11:0] got, e;
    logic cerr, err;
    int lat, bc;
    exp_q.push_back(12'd300);
    in_valid = 1'b1; in_data = 12'd300;
    lat = -1; cerr = 1'b0; got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      in_data  = (c == 3) ? 12'd999 : 12'd300;
      cfg_we   = (c == 5);
      cfg_addr = 6'd0;
      cfg_data = 13'd100;
      if (c == 6) cerr = cfg_err;
      if (out_valid) begin
        lat = c;
        got = out_data;
        break;
      end
    end
    in_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || lat != LAT) begin
      errors++;
      $display("FAIL overrun_out: got %0d at cycle %0d, expected %0d at cycle %0d", $signed(got), lat, $signed(e), LAT);
    end
    checks++;
    if (overrun !== 1'b1 || cerr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flags: got overrun=%b cfg_err=%b, expected 1 1", overrun, cerr);
    end
    write_coef(10, 100, err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_bad_addr: got cfg_err=%b, expected 1", err);
    end
    // Write colliding with an accepted sample: write dropped, sample kept.
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 13'd100;
    exp_q.push_back(12'd77);
    run_sample(77, 1'b0, got, lat, bc);
    cfg_we = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || lat != LAT) begin
      errors++;
      $display("FAIL cfg_collide_out: got %0d at cycle %0d, expected %0d", $signed(got), lat, $signed(e));
    end
    exp_q.push_back(12'd55);
    run_sample(55, 1'b0, got, lat, bc);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL coef_unchanged: got %0d, expected %0d", $signed(got), $signed(e));
    end
  endtask

  task automatic test_reset_mid();
    int outs;
    logic [11:0] got, e;
    logic err;
    int lat, bc;
    write_coef(3, 1024, err);
    pulse_clr();
    in_valid = 1'b1; in_data = 12'd1000;
    outs = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      rst = (c == 9);
      if (c == 10) begin
        checks++;
        if (out_data !== 12'd0 || busy !== 1'b0 || overrun !== 1'b0 || sat_flag !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_state: got data=%0d busy=%b ovr=%b sat=%b, expected 0 0 0 0",
                   $signed(out_data), busy, overrun, sat_flag);
        end
      end
      if (out_valid) outs++;
    end
    checks++;
    if (outs != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d out_valid strobes, expected 0", outs);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back((i == 0) ? 12'd100 : 12'd0);
      run_sample((i == 0) ? 100 : 0, 1'b0, got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL reset_defaults_%0d: got %0d at cycle %0d, expected %0d", i, $signed(got), lat, $signed(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, e;
    logic err;
    int lat, bc, b0, x, p;
    for (int i = 0; i < 8; i++) begin
      b0 = int'($urandom_range(4095, 0));
      x  = int'($urandom_range(4095, 0)) - 2048;
      write_coef(0, b0, err);
      p = (b0 * x) >>> 11;
      if (p > 2047) p = 2047;
      if (p < -2048) p = -2048;
      exp_q.push_back(12'(p));
      run_sample(x, 1'b0, got, lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != LAT) begin
        errors++;
        $display("FAIL random_%0d: b0=%0d x=%0d got %0d at cycle %0d, expected %0d", i, b0, x, $signed(got), lat, $signed(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fir();
    test_iir();
    test_clr();
    test_sat();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
